// File: rtl/chacha_pkg.sv
// Shared definitions for the ChaCha block sequencer.
// Holds the sigma constants, FSM state encoding, default round count and
// word/byte widths used by the sequencer, its interface and the serializer.
package chacha_pkg;

   localparam int WORD_W         = 32;
   localparam int BYTE_W         = 8;
   localparam int DEFAULT_ROUNDS = 20;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      ROUND   = 3'd2,
      CAPTURE = 3'd3,
      EMIT    = 3'd4,
      NEXT    = 3'd5
   } state_t;

   // "expand 32-byte k" as four little-endian words (state words 0..3).
   function automatic logic [WORD_W-1:0] sigma_word(input logic [1:0] idx);
      case (idx)
         2'd0:    return 32'h61707865;
         2'd1:    return 32'h3320646e;
         2'd2:    return 32'h79622d32;
         default: return 32'h6b206574;
      endcase
   endfunction

endpackage

// File: rtl/chacha_sequencer_if.sv
// Bundle of the sequencer's host-side and core-side signals.
//   host config : cfg_we, cfg_addr, cfg_data
//   run control : start, n_blocks, busy
//   keystream   : ks_data, ks_valid, ks_ready, ks_last
//   core port   : core_data_in, core_addr, core_write_n, core_round_n, core_data_out
// master = environment (host + core), slave = chacha_sequencer.
interface chacha_sequencer_if;

   logic                               cfg_we;
   logic [3:0]                         cfg_addr;
   logic [chacha_pkg::WORD_W-1:0]      cfg_data;
   logic                               start;
   logic [7:0]                         n_blocks;
   logic                               busy;
   logic [chacha_pkg::BYTE_W-1:0]      ks_data;
   logic                               ks_valid;
   logic                               ks_ready;
   logic                               ks_last;
   logic [chacha_pkg::WORD_W-1:0]      core_data_in;
   logic [3:0]                         core_addr;
   logic                               core_write_n;
   logic                               core_round_n;
   logic [chacha_pkg::WORD_W-1:0]      core_data_out;

   modport master (
      output cfg_we, cfg_addr, cfg_data, start, n_blocks, ks_ready, core_data_out,
      input  busy, ks_data, ks_valid, ks_last, core_data_in, core_addr,
             core_write_n, core_round_n
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_data, start, n_blocks, ks_ready, core_data_out,
      output busy, ks_data, ks_valid, ks_last, core_data_in, core_addr,
             core_write_n, core_round_n
   );

endinterface

// File: rtl/chacha_ks_serializer.sv
// Splits one 32-bit keystream word into four bytes, LSB first, under a
// valid/ready handshake.
//   load/word_in/last_in : capture a new word (last_in marks word 15)
//   ks_data/ks_valid/ks_last : registered byte stream
//   ks_ready  : consumer accept
//   word_done : pulse when byte 3 of the current word is accepted
module chacha_ks_serializer
   import chacha_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [WORD_W-1:0] word_in,
   input  logic              last_in,
   input  logic              ks_ready,
   output logic [BYTE_W-1:0] ks_data,
   output logic              ks_valid,
   output logic              ks_last,
   output logic              word_done
);

   logic [WORD_W-1:0] shift_q;
   logic [1:0]        idx_q;
   logic              last_word_q;
   logic              valid_q;
   logic              last_q;

   // Shifting right keeps the current byte in the low bits, so ks_data is a
   // flop output and reads zero once the word is drained.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shift_q     <= '0;
         idx_q       <= 2'd0;
         last_word_q <= 1'b0;
         valid_q     <= 1'b0;
         last_q      <= 1'b0;
      end else if (load) begin
         shift_q     <= word_in;
         idx_q       <= 2'd0;
         last_word_q <= last_in;
         valid_q     <= 1'b1;
         last_q      <= 1'b0;
      end else if (valid_q && ks_ready) begin
         shift_q <= shift_q >> BYTE_W;
         idx_q   <= idx_q + 2'd1;
         last_q  <= last_word_q && (idx_q == 2'd2);
         if (idx_q == 2'd3) valid_q <= 1'b0;
      end
   end

   assign ks_data   = shift_q[BYTE_W-1:0];
   assign ks_valid  = valid_q;
   assign ks_last   = last_q;
   assign word_done = valid_q && ks_ready && (idx_q == 2'd3);

endmodule

// File: rtl/chacha_sequencer.sv
// Drives a word-addressed ChaCha core through whole keystream blocks:
// load 16 init words, strobe ROUNDS rounds, read each word back, add the
// init word (feed-forward) and stream the result as bytes.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : host config/run/keystream signals and the core port
module chacha_sequencer
   import chacha_pkg::*;
#(
   parameter int ROUNDS = DEFAULT_ROUNDS
) (
   input  logic             clk,
   input  logic             rst_n,
   chacha_sequencer_if.slave bus
);

   if (ROUNDS < 2 || (ROUNDS % 2) != 0) begin : g_bad_rounds
      $error("ROUNDS must be even and at least 2");
   end

   localparam int CNT_W = $clog2((ROUNDS > 16) ? ROUNDS : 16);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [3:0]        word_idx_q, word_idx_d;
   logic [8:0]        remaining_q, remaining_d;
   logic              busy_q, busy_d;
   logic              write_n_q, write_n_d;
   logic              round_n_q, round_n_d;
   logic [3:0]        addr_q, addr_d;
   logic [WORD_W-1:0] data_in_q, data_in_d;
   logic              cap_load, ctr_inc, word_done;

   logic [WORD_W-1:0] key_q  [4:15];
   logic [WORD_W-1:0] init_w [16];

   always_comb begin
      for (int i = 0; i < 4; i++)  init_w[i] = sigma_word(2'(i));
      for (int i = 4; i < 16; i++) init_w[i] = key_q[i];
   end

   // Host writes only land while idle; the counter word advances once per
   // block so consecutive blocks use consecutive counters.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 4; i < 16; i++) key_q[i] <= '0;
      end else if (state_q == IDLE && bus.cfg_we && bus.cfg_addr >= 4'd4) begin
         key_q[bus.cfg_addr] <= bus.cfg_data;
      end else if (ctr_inc) begin
         key_q[12] <= key_q[12] + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         word_idx_q  <= 4'd0;
         remaining_q <= 9'd0;
         busy_q      <= 1'b0;
         write_n_q   <= 1'b1;
         round_n_q   <= 1'b1;
         addr_q      <= 4'd0;
         data_in_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         word_idx_q  <= word_idx_d;
         remaining_q <= remaining_d;
         busy_q      <= busy_d;
         write_n_q   <= write_n_d;
         round_n_q   <= round_n_d;
         addr_q      <= addr_d;
         data_in_q   <= data_in_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      word_idx_d  = word_idx_q;
      remaining_d = remaining_q;
      cap_load    = 1'b0;
      ctr_inc     = 1'b0;
      case (state_q)
         IDLE: if (bus.start) begin
            state_d     = LOAD;
            cnt_d       = '0;
            // n_blocks == 0 encodes 256 blocks
            remaining_d = {bus.n_blocks == 8'd0, bus.n_blocks};
         end
         LOAD: if (cnt_q == CNT_W'(15)) begin
            state_d = ROUND;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
         ROUND: if (cnt_q == CNT_W'(ROUNDS - 1)) begin
            state_d    = CAPTURE;
            cnt_d      = '0;
            word_idx_d = 4'd0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
         CAPTURE: begin
            cap_load = 1'b1;
            state_d  = EMIT;
         end
         EMIT: if (word_done) begin
            if (word_idx_q == 4'd15) begin
               state_d = NEXT;
            end else begin
               state_d    = CAPTURE;
               word_idx_d = word_idx_q + 4'd1;
            end
         end
         NEXT: begin
            ctr_inc     = 1'b1;
            remaining_d = remaining_q - 9'd1;
            cnt_d       = '0;
            state_d     = (remaining_q == 9'd1) ? IDLE : LOAD;
         end
         default: state_d = IDLE;
      endcase

      // Core strobes are registered from the next state so each strobe is
      // presented for exactly the cycle whose closing edge performs it.
      busy_d    = (state_d != IDLE);
      write_n_d = (state_d != LOAD);
      round_n_d = (state_d != ROUND);
      addr_d    = (state_d == LOAD)    ? cnt_d[3:0] :
                  (state_d == CAPTURE) ? word_idx_d : 4'd0;
      data_in_d = (state_d == LOAD) ? init_w[cnt_d[3:0]] : '0;
   end

   logic [BYTE_W-1:0] ks_data_w;
   logic              ks_valid_w, ks_last_w;

   chacha_ks_serializer u_ser (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (cap_load),
      .word_in   (bus.core_data_out + init_w[word_idx_q]),
      .last_in   (word_idx_q == 4'd15),
      .ks_ready  (bus.ks_ready),
      .ks_data   (ks_data_w),
      .ks_valid  (ks_valid_w),
      .ks_last   (ks_last_w),
      .word_done (word_done)
   );

   assign bus.busy         = busy_q;
   assign bus.ks_data      = ks_data_w;
   assign bus.ks_valid     = ks_valid_w;
   assign bus.ks_last      = ks_last_w;
   assign bus.core_data_in = data_in_q;
   assign bus.core_addr    = addr_q;
   assign bus.core_write_n = write_n_q;
   assign bus.core_round_n = round_n_q;

endmodule

// File: tb/tb_chacha_sequencer.sv
// Directed bench for chacha_sequencer with a behavioural word-addressed
// ChaCha core and an independent full-block reference (RFC 8439 vectors).
module tb_chacha_sequencer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   chacha_sequencer_if bus ();

   chacha_sequencer #(.ROUNDS(20)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   function automatic logic [127:0] qr(input logic [31:0] a0, b0, c0, d0);
      logic [31:0] a, b, c, d;
      a = a0; b = b0; c = c0; d = d0;
      a = a + b; d = rotl(d ^ a, 16);
      c = c + d; b = rotl(b ^ c, 12);
      a = a + b; d = rotl(d ^ a, 8);
      c = c + d; b = rotl(b ^ c, 7);
      return {a, b, c, d};
   endfunction

   // ---------------- behavioural core ----------------
   logic [31:0] core_st [16];
   logic [31:0] rnd_st  [16];
   logic        core_diag;

   always_comb begin
      rnd_st = core_st;
      if (!core_diag) begin
         {rnd_st[0], rnd_st[4], rnd_st[8],  rnd_st[12]} = qr(core_st[0], core_st[4], core_st[8],  core_st[12]);
         {rnd_st[1], rnd_st[5], rnd_st[9],  rnd_st[13]} = qr(core_st[1], core_st[5], core_st[9],  core_st[13]);
         {rnd_st[2], rnd_st[6], rnd_st[10], rnd_st[14]} = qr(core_st[2], core_st[6], core_st[10], core_st[14]);
         {rnd_st[3], rnd_st[7], rnd_st[11], rnd_st[15]} = qr(core_st[3], core_st[7], core_st[11], core_st[15]);
      end else begin
         {rnd_st[0], rnd_st[5], rnd_st[10], rnd_st[15]} = qr(core_st[0], core_st[5], core_st[10], core_st[15]);
         {rnd_st[1], rnd_st[6], rnd_st[11], rnd_st[12]} = qr(core_st[1], core_st[6], core_st[11], core_st[12]);
         {rnd_st[2], rnd_st[7], rnd_st[8],  rnd_st[13]} = qr(core_st[2], core_st[7], core_st[8],  core_st[13]);
         {rnd_st[3], rnd_st[4], rnd_st[9],  rnd_st[14]} = qr(core_st[3], core_st[4], core_st[9],  core_st[14]);
      end
   end

   always @(posedge clk) begin
      if (!rst_n) begin
         core_diag <= 1'b0;
      end else if (!bus.core_write_n) begin
         core_st[bus.core_addr] <= bus.core_data_in;
         core_diag <= 1'b0;
      end else if (!bus.core_round_n) begin
         for (int i = 0; i < 16; i++) core_st[i] <= rnd_st[i];
         core_diag <= ~core_diag;
      end
   end

   assign bus.core_data_out = core_st[bus.core_addr];

   // ---------------- strobe monitor ----------------
   int mon_wr = 0, mon_rd = 0, mon_both = 0;
   always @(posedge clk) begin
      if (!bus.core_write_n) mon_wr <= mon_wr + 1;
      if (!bus.core_round_n) mon_rd <= mon_rd + 1;
      if (!bus.core_write_n && !bus.core_round_n) mon_both <= mon_both + 1;
   end

   // ---------------- reference block ----------------
   logic [31:0] cfg_key   [8];
   logic [31:0] cfg_nonce [3];
   logic [7:0]  exp_b     [64];
   logic [7:0]  got_b     [128];
   logic [7:0]  rfc16     [16] = '{8'h10, 8'hf1, 8'he7, 8'he4, 8'hd1, 8'h3b, 8'h59, 8'h15,
                                   8'h50, 8'h0f, 8'hdd, 8'h1f, 8'ha3, 8'h20, 8'h71, 8'hc4};

   task automatic compute_ref(input logic [31:0] ctr);
      logic [31:0] s [16];
      logic [31:0] x [16];
      logic [31:0] w;
      s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
      for (int i = 0; i < 8; i++) s[4 + i] = cfg_key[i];
      s[12] = ctr;
      for (int i = 0; i < 3; i++) s[13 + i] = cfg_nonce[i];
      x = s;
      for (int r = 0; r < 10; r++) begin
         {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
         {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
         {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
         {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
         {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
         {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
         {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
         {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
      end
      for (int i = 0; i < 16; i++) begin
         w = x[i] + s[i];
         for (int b = 0; b < 4; b++) exp_b[4 * i + b] = w[8 * b +: 8];
      end
   endtask

   task automatic cmp_block(input string tag, input int base, input logic [31:0] ctr);
      int mism;
      compute_ref(ctr);
      mism = 0;
      for (int i = 0; i < 64; i++) if (got_b[base + i] !== exp_b[i]) mism++;
      check_val(tag, mism, 0);
   endtask

   // ---------------- host helpers ----------------
   task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_data = d;
      @(negedge clk);
      bus.cfg_we = 1'b0;
   endtask

   task automatic program_all(input logic [31:0] ctr);
      for (int i = 0; i < 8; i++) cfg_write(4'(4 + i), cfg_key[i]);
      cfg_write(4'd12, ctr);
      for (int i = 0; i < 3; i++) cfg_write(4'(13 + i), cfg_nonce[i]);
   endtask

   task automatic check_reset(input string pfx);
      check_val({pfx, "_busy"},     bus.busy,         0);
      check_val({pfx, "_ks_valid"}, bus.ks_valid,     0);
      check_val({pfx, "_ks_last"},  bus.ks_last,      0);
      check_val({pfx, "_ks_data"},  bus.ks_data,      0);
      check_val({pfx, "_data_in"},  bus.core_data_in, 0);
      check_val({pfx, "_addr"},     bus.core_addr,    0);
      check_val({pfx, "_write_n"},  bus.core_write_n, 1);
      check_val({pfx, "_round_n"},  bus.core_round_n, 1);
   endtask

   // run results
   int nbytes, nlast, last_bad, stall_bad, first_cyc, last_cyc, fall_cyc;
   int st_wr, st_rd, st_both;

   // mode 0: ready high, 1: random ready, 2: start/cfg_we poked while busy,
   // 3: reset asserted after 20 bytes
   task automatic run_blocks(input logic [7:0] nb, input int mode);
      int cyc, wr0, rd0, both0;
      bit pend_rst, rst_done, prev_stall, rdy;
      logic [7:0] prev_data;
      nbytes = 0; nlast = 0; last_bad = 0; stall_bad = 0;
      first_cyc = -1; last_cyc = -1; fall_cyc = -1;
      pend_rst = 0; rst_done = 0; prev_stall = 0; prev_data = '0;
      for (int i = 0; i < 128; i++) got_b[i] = 'x;
      wr0 = mon_wr; rd0 = mon_rd; both0 = mon_both;
      @(negedge clk);
      bus.start = 1'b1; bus.n_blocks = nb; bus.ks_ready = 1'b1;
      cyc = 0;
      while (cyc < 3000) begin
         @(negedge clk);
         cyc++;
         bus.start = 1'b0; bus.cfg_we = 1'b0;
         if (pend_rst) begin
            check_reset("mid_rst");
            rst_n = 1'b1;
            pend_rst = 0;
         end
         if (prev_stall && (!bus.ks_valid || bus.ks_data !== prev_data)) stall_bad++;
         if (!bus.busy) begin
            fall_cyc = cyc;
            break;
         end
         if (mode == 2 && cyc == 50) begin
            bus.start = 1'b1; bus.n_blocks = 8'd3;
            bus.cfg_we = 1'b1; bus.cfg_addr = 4'd5; bus.cfg_data = 32'hdeadbeef;
         end
         rdy = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.ks_ready = rdy;
         prev_stall = bus.ks_valid && !rdy;
         prev_data  = bus.ks_data;
         if (bus.ks_valid && rdy) begin
            if (bus.ks_last !== ((nbytes % 64) == 63)) last_bad++;
            if (bus.ks_last) begin nlast++; last_cyc = cyc; end
            if (nbytes == 0) first_cyc = cyc;
            if (nbytes < 128) got_b[nbytes] = bus.ks_data;
            nbytes++;
         end else if (bus.ks_last && !bus.ks_valid) begin
            last_bad++;
         end
         if (mode == 3 && nbytes == 20 && !rst_done) begin
            rst_n = 1'b0; pend_rst = 1; rst_done = 1;
         end
      end
      bus.ks_ready = 1'b1;
      check_val("run_terminated", fall_cyc > 0, 1);
      st_wr = mon_wr - wr0; st_rd = mon_rd - rd0; st_both = mon_both - both0;
   endtask

   task automatic check_strobes(input string tag, input int nb);
      check_val({tag, "_writes"}, st_wr, 16 * nb);
      check_val({tag, "_rounds"}, st_rd, 20 * nb);
      check_val({tag, "_both_low"}, st_both, 0);
   endtask

   initial begin
      bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_data = 0;
      bus.start = 0; bus.n_blocks = 0; bus.ks_ready = 1;
      for (int i = 0; i < 8; i++)
         cfg_key[i] = {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)};
      cfg_nonce[0] = 32'h09000000; cfg_nonce[1] = 32'h4a000000; cfg_nonce[2] = 32'h00000000;

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset("por");
      rst_n = 1'b1;

      // RFC 8439 block, consumer always ready
      program_all(32'd1);
      run_blocks(8'd1, 0);
      for (int i = 0; i < 16; i++) check_val($sformatf("rfc_byte%0d", i), got_b[i], rfc16[i]);
      cmp_block("rfc_block", 0, 32'd1);
      check_val("rfc_nbytes", nbytes, 64);
      check_val("rfc_first_cyc", first_cyc, 38);
      check_val("rfc_last_cyc", last_cyc, 116);
      check_val("rfc_nlast", nlast, 1);
      check_val("rfc_last_pos", last_bad, 0);
      check_val("rfc_busy_fall", fall_cyc, 118);
      check_strobes("rfc", 1);

      // same block under random backpressure
      cfg_write(4'd12, 32'd1);
      run_blocks(8'd1, 1);
      cmp_block("bp_block", 0, 32'd1);
      check_val("bp_nbytes", nbytes, 64);
      check_val("bp_stall_stable", stall_bad, 0);
      check_val("bp_last_pos", last_bad, 0);
      check_strobes("bp", 1);

      // start and cfg_we while busy are ignored
      cfg_write(4'd12, 32'd1);
      run_blocks(8'd1, 2);
      cmp_block("busy_poke_block", 0, 32'd1);
      check_val("busy_poke_fall", fall_cyc, 118);
      check_val("busy_poke_nlast", nlast, 1);
      check_strobes("busy_poke", 1);

      // two blocks across the counter wrap
      cfg_write(4'd12, 32'hffffffff);
      run_blocks(8'd2, 0);
      cmp_block("wrap_blk0", 0, 32'hffffffff);
      cmp_block("wrap_blk1", 64, 32'd0);
      check_val("wrap_nbytes", nbytes, 128);
      check_val("wrap_nlast", nlast, 2);
      check_val("wrap_last_pos", last_bad, 0);
      check_val("wrap_busy_fall", fall_cyc, 235);
      check_strobes("wrap", 2);

      // counter left at 0xffffffff + 2 = 1
      run_blocks(8'd1, 0);
      cmp_block("post_wrap_ctr", 0, 32'd1);

      // reset after byte 20, then a fresh block from the cleared register file
      cfg_write(4'd12, 32'd1);
      run_blocks(8'd1, 3);
      check_val("rst_nbytes", nbytes, 20);
      check_strobes("rst", 1);
      for (int i = 0; i < 8; i++) cfg_key[i] = '0;
      for (int i = 0; i < 3; i++) cfg_nonce[i] = '0;
      run_blocks(8'd1, 0);
      cmp_block("after_rst_block", 0, 32'd0);
      check_val("after_rst_nbytes", nbytes, 64);
      check_val("after_rst_first", first_cyc, 38);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
